// File: rtl/nor_sync_counter.sv
// Loadable up/down binary counter with terminal-count and wrap outputs.
// Next-state decode is built only from NOR2 primitives feeding async-clear flops.
module nor_sync_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    function automatic logic nor2(input logic a, input logic b);
        return ~(a | b);
    endfunction

    function automatic logic inv(input logic a);
        return nor2(a, a);
    endfunction

    function automatic logic or2(input logic a, input logic b);
        return inv(nor2(a, b));
    endfunction

    function automatic logic and2(input logic a, input logic b);
        return nor2(inv(a), inv(b));
    endfunction

    // Four-NOR XNOR: the two inner gates detect "exactly one input high".
    function automatic logic xnor2(input logic a, input logic b);
        logic n1;
        n1 = nor2(a, b);
        return nor2(nor2(a, n1), nor2(b, n1));
    endfunction

    function automatic logic xor2(input logic a, input logic b);
        return inv(xnor2(a, b));
    endfunction

    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] next_count;
    logic             count_en;

    // chain[i] is high when every lower bit is 1 (counting up) or 0 (counting
    // down), so bit i toggles on a step; chain[WIDTH] marks the terminal state.
    always_comb begin
        chain      = '0;
        next_count = '0;
        chain[0]   = 1'b1;
        count_en   = and2(en, inv(load));
        for (int i = 0; i < WIDTH; i++) begin
            chain[i+1]    = and2(chain[i], xnor2(up, count[i]));
            next_count[i] = or2(and2(load, din[i]),
                                and2(inv(load), xor2(count[i], and2(chain[i], en))));
        end
        tc = and2(count_en, chain[WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= tc;
        end
    end

endmodule
